// File: rtl/phrase_char_decoder.sv
// phrase_char_decoder
//   Turns a 6-character text cell (LETTER ACC OCT VT VO INST) back into the
//   packed phrase word {note[15:8], volume[7:2], instrument[1:0]}. Every
//   character is validated. The first error in a cell is latched. One finished
//   phrase is buffered and handed off with a valid/ready handshake.
//
// Ports
//   clk           system clock, rising edge
//   aresetn       asynchronous reset, active low
//   char_in[6:0]  character code
//   char_sop      char_in is the first character of a cell
//   char_valid    char_in / char_sop valid
//   char_ready    character accepted this cycle (low only while a phrase waits)
//   phrase_out    decoded phrase word (0 when the cell had an error)
//   phrase_err    presented phrase failed validation
//   err_code      first error: 0 letter, 1 accidental, 2 non-digit, 3 range
//   phrase_valid  phrase_out / phrase_err / err_code valid
//   phrase_ready  consumer takes the phrase
//   abort         one-cycle pulse when a partial cell was discarded by sop
module phrase_char_decoder (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [6:0]  char_in,
  input  logic        char_sop,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [15:0] phrase_out,
  output logic        phrase_err,
  output logic [1:0]  err_code,
  output logic        phrase_valid,
  input  logic        phrase_ready,
  output logic        abort
);

  typedef enum logic [2:0] {
    S_LET, S_ACC, S_OCT, S_VT, S_VO, S_INST, S_OUT
  } state_t;

  localparam logic [1:0] E_LETTER = 2'd0;
  localparam logic [1:0] E_ACC    = 2'd1;
  localparam logic [1:0] E_DIGIT  = 2'd2;
  localparam logic [1:0] E_RANGE  = 2'd3;

  state_t      state_q;
  logic [3:0]  idx_q;       // semitone index within the octave
  logic        no_sharp_q;  // E and B have no sharp
  logic [7:0]  note_q;
  logic [3:0]  vt_q;
  logic [5:0]  vol_q;
  logic        err_q;
  logic [1:0]  code_q;
  logic [15:0] phrase_q;
  logic        perr_q;
  logic [1:0]  pcode_q;
  logic        pvld_q;
  logic        abort_q;

  // ---------------------------------------------------------------------------
  // Character classification
  // ---------------------------------------------------------------------------
  logic       accept;
  logic       let_ok;
  logic [3:0] let_idx;
  logic       let_no_sharp;
  logic       dig_ok;
  logic [3:0] dig_val;
  logic [6:0] vol_sum;
  logic [7:0] note_sum;
  logic       chk_err;
  logic [1:0] chk_code;
  logic       fin_err;
  logic [1:0] fin_code;

  assign char_ready = (state_q != S_OUT);
  assign accept     = char_valid & char_ready;

  assign dig_ok  = (char_in >= 7'h30) && (char_in <= 7'h39);
  assign dig_val = char_in[3:0];

  always_comb begin
    let_ok       = 1'b1;
    let_idx      = 4'd0;
    let_no_sharp = 1'b0;
    case (char_in)
      7'h43:   let_idx = 4'd0;                          // C
      7'h44:   let_idx = 4'd2;                          // D
      7'h45: begin let_idx = 4'd4;  let_no_sharp = 1'b1; end // E
      7'h46:   let_idx = 4'd5;                          // F
      7'h47:   let_idx = 4'd7;                          // G
      7'h41:   let_idx = 4'd9;                          // A
      7'h42: begin let_idx = 4'd11; let_no_sharp = 1'b1; end // B
      default: let_ok = 1'b0;
    endcase
  end

  // Garbage from non-digit characters only reaches these sums in cells that
  // already carry a latched error, so the results are never published.
  assign vol_sum  = 7'(vt_q) * 7'd10 + 7'(dig_val);
  assign note_sum = 8'(dig_val) * 8'd12 + 8'(idx_q);

  // Error raised by the current character in the states after LETTER.
  always_comb begin
    chk_err  = 1'b0;
    chk_code = E_LETTER;
    case (state_q)
      S_ACC: begin
        if (char_in == 7'h23) begin
          if (no_sharp_q) begin chk_err = 1'b1; chk_code = E_ACC; end
        end else if ((char_in != 7'h00) && (char_in != 7'h20)) begin
          chk_err = 1'b1; chk_code = E_ACC;
        end
      end
      S_OCT, S_VT: begin
        if (!dig_ok) begin chk_err = 1'b1; chk_code = E_DIGIT; end
      end
      S_VO: begin
        if (!dig_ok)             begin chk_err = 1'b1; chk_code = E_DIGIT; end
        else if (vol_sum > 7'd63) begin chk_err = 1'b1; chk_code = E_RANGE; end
      end
      S_INST: begin
        if (!dig_ok)                begin chk_err = 1'b1; chk_code = E_DIGIT; end
        else if (dig_val > 4'd3)     begin chk_err = 1'b1; chk_code = E_RANGE; end
      end
      default: ;
    endcase
  end

  // Error status of the whole cell including the INST character itself.
  assign fin_err  = err_q | chk_err;
  assign fin_code = err_q ? code_q : chk_code;

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_LET;
      idx_q      <= 4'd0;
      no_sharp_q <= 1'b0;
      note_q     <= 8'd0;
      vt_q       <= 4'd0;
      vol_q      <= 6'd0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
      phrase_q   <= 16'd0;
      perr_q     <= 1'b0;
      pcode_q    <= 2'd0;
      pvld_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      if (state_q == S_OUT) begin
        if (phrase_ready) begin
          pvld_q  <= 1'b0;
          state_q <= S_LET;
          err_q   <= 1'b0;
          code_q  <= 2'd0;
        end
      end else if (accept) begin
        if ((state_q == S_LET) || char_sop) begin
          // Cell start: a sop outside S_LET drops the partial cell and this
          // character is taken as the new LETTER with a clean error latch.
          abort_q    <= (state_q != S_LET);
          state_q    <= S_ACC;
          idx_q      <= let_idx;
          no_sharp_q <= let_no_sharp;
          err_q      <= !let_ok;
          code_q     <= E_LETTER;
        end else begin
          if (chk_err && !err_q) begin
            err_q  <= 1'b1;
            code_q <= chk_code;
          end
          case (state_q)
            S_ACC: begin
              if (char_in == 7'h23) idx_q <= idx_q + 4'd1;
              state_q <= S_OCT;
            end
            S_OCT: begin
              note_q  <= note_sum;
              state_q <= S_VT;
            end
            S_VT: begin
              vt_q    <= dig_val;
              state_q <= S_VO;
            end
            S_VO: begin
              vol_q   <= vol_sum[5:0];
              state_q <= S_INST;
            end
            S_INST: begin
              pvld_q   <= 1'b1;
              perr_q   <= fin_err;
              pcode_q  <= fin_err ? fin_code : 2'd0;
              phrase_q <= fin_err ? 16'h0000 : {note_q, vol_q, char_in[1:0]};
              state_q  <= S_OUT;
            end
            default: state_q <= S_LET;
          endcase
        end
      end
    end
  end

  assign phrase_out   = phrase_q;
  assign phrase_err   = perr_q;
  assign err_code     = pcode_q;
  assign phrase_valid = pvld_q;
  assign abort        = abort_q;

endmodule
